// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and defaults for the serial receive sequencer
package rx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START_CHK,
    RECV,
    STOP_CHK,
    FRAME_EVAL,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter that wraps to 0 after reaching rollover_val
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  logic [NUM_BITS-1:0] count_q;
  logic [NUM_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rx_sequencer.sv
// rtl/rx_sequencer.sv - per-frame control of the serial receive datapath
module rx_sequencer
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ERR_W        = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             serial_in,
  input  logic             start_bit_detected,
  input  logic             packet_done,
  input  logic             framing_error,
  input  logic             data_read,
  output logic             enable_timer,
  output logic             sbc_clear,
  output logic             sbc_enable,
  output logic             load_buffer,
  output logic             data_ready,
  output logic             overrun_error,
  output logic [ERR_W-1:0] err_count
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(HALF) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  rx_state_t        state_q;
  rx_state_t        state_d;
  logic             data_ready_q;
  logic             data_ready_d;
  logic             overrun_q;
  logic             overrun_d;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;

  logic [CNT_W-1:0] half_cnt;
  logic             half_done;

  flex_counter #(
    .NUM_BITS(CNT_W)
  ) u_half_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state_q == CLEAR),
    .count_enable (state_q == START_CHK),
    .rollover_val (HALF_LAST),
    .count_out    (half_cnt),
    .rollover_flag(half_done)
  );

  always_comb begin
    state_d      = state_q;
    enable_timer = 1'b0;
    sbc_clear    = 1'b0;
    sbc_enable   = 1'b0;
    load_buffer  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_bit_detected) state_d = CLEAR;
      end
      CLEAR: begin
        sbc_clear = 1'b1;
        state_d   = START_CHK;
      end
      START_CHK: begin
        // Mid-bit sample: a high line means the start edge was a glitch.
        if (half_done) state_d = serial_in ? IDLE : RECV;
      end
      RECV: begin
        enable_timer = 1'b1;
        if (packet_done) state_d = STOP_CHK;
      end
      STOP_CHK: begin
        sbc_enable = 1'b1;
        state_d    = FRAME_EVAL;
      end
      FRAME_EVAL: begin
        state_d = framing_error ? IDLE : LOAD;
      end
      LOAD: begin
        load_buffer = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    err_count_d  = err_count_q;
    if (load_buffer) begin
      data_ready_d = 1'b1;
    end else if (data_read) begin
      data_ready_d = 1'b0;
    end
    // A read coinciding with a load consumes the old byte, so no overrun.
    if (data_read) begin
      overrun_d = 1'b0;
    end else if (load_buffer && data_ready_q) begin
      overrun_d = 1'b1;
    end
    if (state_q == FRAME_EVAL && framing_error && err_count_q != ERR_MAX) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// tb/tb_rx_sequencer.sv - directed self-checking bench for rx_sequencer
module tb_rx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       serial_in;
  logic       start_bit_detected;
  logic       packet_done;
  logic       framing_error;
  logic       data_read;
  logic       enable_timer;
  logic       sbc_clear;
  logic       sbc_enable;
  logic       load_buffer;
  logic       data_ready;
  logic       overrun_error;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  rx_sequencer #(
    .CLKS_PER_BIT(10),
    .ERR_W       (8)
  ) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .serial_in         (serial_in),
    .start_bit_detected(start_bit_detected),
    .packet_done       (packet_done),
    .framing_error     (framing_error),
    .data_read         (data_read),
    .enable_timer      (enable_timer),
    .sbc_clear         (sbc_clear),
    .sbc_enable        (sbc_enable),
    .load_buffer       (load_buffer),
    .data_ready        (data_ready),
    .overrun_error     (overrun_error),
    .err_count         (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes_idle(input string tag);
    check_eq({tag, "_strobes"}, {enable_timer, sbc_clear, sbc_enable, load_buffer}, 4'b0000);
  endtask

  // Drives the start pulse and waits for RECV; returns edges counted from the pulse.
  task automatic enter_recv(output int n);
    serial_in          = 1'b0;
    start_bit_detected = 1'b1;
    tick();
    start_bit_detected = 1'b0;
    n = 1;
    check_eq("sbc_clear_after_start", sbc_clear, 1'b1);
    while (!enable_timer && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic run_frame(input logic fe, input logic read_at_load);
    int n;
    enter_recv(n);
    check_eq("start_to_enable_timer", n, 7);
    start_bit_detected = 1'b1;
    tick();
    start_bit_detected = 1'b0;
    check_eq("recv_ignores_start", enable_timer, 1'b1);
    tick();
    tick();
    check_eq("recv_holds", enable_timer, 1'b1);
    serial_in     = 1'b1;
    framing_error = fe;
    packet_done   = 1'b1;
    tick();
    packet_done = 1'b0;
    check_eq("sbc_enable_after_done", {enable_timer, sbc_enable}, 2'b01);
    tick();
    check_eq("frame_eval_quiet", {sbc_enable, load_buffer}, 2'b00);
    tick();
    check_eq("load_buffer_3_after_done", load_buffer, !fe);
    framing_error = 1'b0;
    data_read     = read_at_load;
    tick();
    data_read = 1'b0;
    check_strobes_idle("post_frame");
  endtask

  initial begin
    int n;
    logic [7:0] err_before;
    n_rst              = 1'b0;
    serial_in          = 1'b1;
    start_bit_detected = 1'b0;
    packet_done        = 1'b0;
    framing_error      = 1'b0;
    data_read          = 1'b0;
    #23;
    check_strobes_idle("reset");
    check_eq("reset_status", {data_ready, overrun_error}, 2'b00);
    check_eq("reset_err_count", err_count, 0);
    n_rst = 1'b1;
    tick();

    // Good frame
    run_frame(1'b0, 1'b0);
    check_eq("good_data_ready", data_ready, 1'b1);
    check_eq("good_no_overrun", overrun_error, 1'b0);
    check_eq("good_err_count", err_count, 0);

    // Single framing error
    run_frame(1'b1, 1'b0);
    check_eq("fe_err_count", err_count, 1);
    check_eq("fe_data_ready_kept", {data_ready, overrun_error}, 2'b10);

    // Reset in the middle of RECV
    enter_recv(n);
    check_eq("pre_reset_recv", enable_timer, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    check_strobes_idle("midframe_reset");
    check_eq("midframe_reset_status", {data_ready, overrun_error}, 2'b00);
    check_eq("midframe_reset_err", err_count, 0);
    tick();
    #3 n_rst = 1'b1;
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    tick();
    tick();
    check_strobes_idle("after_release");
    check_eq("after_release_status", {data_ready, overrun_error}, 2'b00);

    // False start: line returns high before the mid-bit sample
    err_before         = err_count;
    serial_in          = 1'b0;
    start_bit_detected = 1'b1;
    tick();
    start_bit_detected = 1'b0;
    tick();
    serial_in = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (enable_timer) n++;
    end
    check_eq("false_start_no_timer", n, 0);
    check_eq("false_start_err", err_count, err_before);
    check_strobes_idle("false_start_idle");

    // Spurious packet_done in IDLE
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    check_strobes_idle("idle_packet_done");
    tick();
    check_strobes_idle("idle_packet_done_next");

    // Overrun without read, then cleared by data_read
    run_frame(1'b0, 1'b0);
    check_eq("ov1_status", {data_ready, overrun_error}, 2'b10);
    run_frame(1'b0, 1'b0);
    check_eq("ov2_status", {data_ready, overrun_error}, 2'b11);
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    check_eq("ov_read_clears", {data_ready, overrun_error}, 2'b00);

    // Read coincident with the second load: no overrun
    run_frame(1'b0, 1'b0);
    check_eq("ovr_first", {data_ready, overrun_error}, 2'b10);
    run_frame(1'b0, 1'b1);
    check_eq("ovr_read_at_load", {data_ready, overrun_error}, 2'b10);

    // Saturation: 256 framing errors from a known base
    n_rst = 1'b0;
    #2 n_rst = 1'b1;
    tick();
    check_eq("sat_base", err_count, 0);
    for (int i = 0; i < 255; i++) run_frame(1'b1, 1'b0);
    check_eq("sat_255", err_count, 255);
    run_frame(1'b1, 1'b0);
    check_eq("sat_256_holds", err_count, 255);
    check_eq("sat_no_load", data_ready, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
